// File: rtl/rtc_write_seq.sv
// rtl/rtc_write_seq.sv - RTC bus write master and periodic read-burst scheduler
// Serialises register writes onto the muxed RTC bus and yields the bus to the read sequencer.
module rtc_write_seq #(
  parameter int RD_PERIOD = 1000000,
  parameter int RD_WINDOW = 450,
  parameter int CNT_W     = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       busy,
  output logic       chs,
  output logic       bus_sel,
  output logic [7:0] ADout,
  output logic       ad,
  output logic       wr,
  output logic       rd,
  output logic       cs
);

  localparam int         WIN_W    = (RD_WINDOW > 1) ? $clog2(RD_WINDOW) : 1;
  localparam logic [5:0] PH_LAST  = 6'd40;
  localparam logic [7:0] BUS_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_RDWIN
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       phase_q, phase_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             trig_pend_q, trig_pend_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             wr_ack_q, wr_ack_d;
  logic             chs_q, chs_d;
  logic             busy_q, busy_d;
  logic             bus_sel_q, bus_sel_d;
  logic [7:0]       adout_q, adout_d;
  logic             ad_q, ad_d;
  logic             wr_q, wr_d;
  logic             cs_q, cs_d;
  logic             rd_q;

  logic             wrap;
  logic             trig_clr;
  logic [5:0]       phase_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      per_q       <= '0;
      trig_pend_q <= 1'b0;
      win_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_ack_q    <= 1'b0;
      chs_q       <= 1'b0;
      busy_q      <= 1'b0;
      bus_sel_q   <= 1'b0;
      adout_q     <= BUS_IDLE;
      ad_q        <= 1'b1;
      wr_q        <= 1'b1;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      per_q       <= per_d;
      trig_pend_q <= trig_pend_d;
      win_q       <= win_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_ack_q    <= wr_ack_d;
      chs_q       <= chs_d;
      busy_q      <= busy_d;
      bus_sel_q   <= bus_sel_d;
      adout_q     <= adout_d;
      ad_q        <= ad_d;
      wr_q        <= wr_d;
      cs_q        <= cs_d;
      rd_q        <= 1'b1;
    end
  end

  // Output registers are loaded from next-state values so each bus action
  // is visible in the same cycle the phase counter shows its phase.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    win_d     = win_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_ack_d  = 1'b0;
    chs_d     = 1'b0;
    bus_sel_d = bus_sel_q;
    adout_d   = adout_q;
    ad_d      = ad_q;
    wr_d      = wr_q;
    cs_d      = cs_q;
    trig_clr  = 1'b0;
    phase_nxt = phase_q + 6'd1;

    wrap  = (per_q == CNT_W'(RD_PERIOD - 1));
    per_d = wrap ? '0 : per_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (trig_pend_q) begin
          chs_d     = 1'b1;
          trig_clr  = 1'b1;
          bus_sel_d = 1'b0;
          win_d     = WIN_W'(RD_WINDOW - 1);
          state_d   = S_RDWIN;
        end else if (wr_req) begin
          wr_ack_d  = 1'b1;
          addr_d    = wr_addr;
          data_d    = wr_data;
          bus_sel_d = 1'b1;
          phase_d   = '0;
          adout_d   = BUS_IDLE;
          ad_d      = 1'b1;
          wr_d      = 1'b1;
          cs_d      = 1'b1;
          state_d   = S_WRITE;
        end
      end

      S_RDWIN: begin
        bus_sel_d = 1'b0;
        if (win_q == '0) begin
          state_d = S_IDLE;
        end else begin
          win_d = win_q - WIN_W'(1);
        end
      end

      S_WRITE: begin
        if (phase_q == PH_LAST) begin
          bus_sel_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          phase_d = phase_nxt;
          case (phase_nxt)
            6'd1:    ad_d    = 1'b0;
            6'd2:    cs_d    = 1'b0;
            6'd3:    wr_d    = 1'b0;
            6'd4:    adout_d = addr_q;
            6'd9:    wr_d    = 1'b1;
            6'd10:   cs_d    = 1'b1;
            6'd11:   ad_d    = 1'b1;
            6'd13:   adout_d = BUS_IDLE;
            6'd21:   cs_d    = 1'b0;
            6'd22:   wr_d    = 1'b0;
            6'd23:   adout_d = data_q;
            6'd28:   wr_d    = 1'b1;
            6'd29:   cs_d    = 1'b1;
            6'd31:   adout_d = BUS_IDLE;
            default: ;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A wrap coinciding with a chs issue must not be lost.
    trig_pend_d = wrap ? 1'b1 : (trig_clr ? 1'b0 : trig_pend_q);
    busy_d      = (state_d != S_IDLE);
  end

  assign wr_ack  = wr_ack_q;
  assign busy    = busy_q;
  assign chs     = chs_q;
  assign bus_sel = bus_sel_q;
  assign ADout   = adout_q;
  assign ad      = ad_q;
  assign wr      = wr_q;
  assign rd      = rd_q;
  assign cs      = cs_q;

endmodule

// File: tb/tb_rtc_write_seq.sv
// tb/tb_rtc_write_seq.sv - self-checking bench for rtc_write_seq
// Directed tables and sequences plus randomized requests against a schedule-level model.
module tb_rtc_write_seq;

  localparam int P    = 100;
  localparam int W    = 20;
  localparam int LOGN = 8192;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack, busy, chs, bus_sel, ad, wr, rd, cs;
  logic [7:0] ADout;

  rtc_write_seq #(.RD_PERIOD(P), .RD_WINDOW(W), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .busy(busy), .chs(chs), .bus_sel(bus_sel), .ADout(ADout),
    .ad(ad), .wr(wr), .rd(rd), .cs(cs)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         avail;
  } req_t;

  typedef struct {
    int          phase;
    logic [15:0] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  req_t        rq[$];
  int          edge_n;
  logic [15:0] log_v [0:LOGN-1];

  // Model: when the block is next free, what it is doing, and since which edge.
  int          m_free, m_wstart, m_rstart;
  logic [7:0]  m_addr, m_data;
  bit          m_pend;

  function automatic logic [15:0] outv();
    return {wr_ack, busy, chs, bus_sel, ADout, ad, wr, rd, cs};
  endfunction

  function automatic logic [15:0] mk(bit ack, bit bsy, bit sel, logic [7:0] d, bit a, bit w, bit c);
    return {ack, bsy, 1'b0, sel, d, a, w, 1'b1, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int first_set(int bitpos, int from, int to);
    for (int i = from; i <= to && i < LOGN; i++)
      if (i >= 0 && log_v[i][bitpos]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_free   = 0;
    m_wstart = -100000;
    m_rstart = -100000;
    m_pend   = 0;
    m_addr   = '0;
    m_data   = '0;
    edge_n   = 0;
    rq.delete();
    foreach (log_v[i]) log_v[i] = '0;
  endtask

  task automatic model_step(input int e, output logic [15:0] exp, output bit ack);
    int ph;
    int rp;
    bit inw, inr;
    logic [7:0] d;
    ack = 0;
    if (e >= m_free) begin
      if (m_pend) begin
        m_rstart = e;
        m_free   = e + W + 1;
        m_pend   = 0;
      end else if (wr_req) begin
        m_wstart = e;
        m_addr   = wr_addr;
        m_data   = wr_data;
        m_free   = e + 42;
        ack      = 1;
      end
    end
    if (e % P == P - 1) m_pend = 1;
    ph  = e - m_wstart;
    rp  = e - m_rstart;
    inw = (ph >= 0) && (ph <= 40);
    inr = (rp >= 0) && (rp < W);
    d   = 8'hFF;
    if (inw && ph >= 4 && ph <= 12) d = m_addr;
    if (inw && ph >= 23 && ph <= 30) d = m_data;
    exp = {ack, inw || inr, rp == 0, inw, d,
           !(inw && ph >= 1 && ph <= 10),
           !(inw && ((ph >= 3 && ph <= 8) || (ph >= 22 && ph <= 27))),
           1'b1,
           !(inw && ((ph >= 2 && ph <= 9) || (ph >= 21 && ph <= 28)))};
  endtask

  task automatic drive(input int ne);
    if (rq.size() > 0 && rq[0].avail <= ne) begin
      wr_req  = 1'b1;
      wr_addr = rq[0].addr;
      wr_data = rq[0].data;
    end else begin
      wr_req  = 1'b0;
      wr_addr = 8'($urandom);
      wr_data = 8'($urandom);
    end
  endtask

  task automatic cycle();
    logic [15:0] exp;
    bit ack;
    @(posedge clock);
    @(negedge clock);
    model_step(edge_n, exp, ack);
    check($sformatf("cycle@%0d", edge_n), outv(), exp);
    if (edge_n < LOGN) log_v[edge_n] = outv();
    if (ack && rq.size() > 0) void'(rq.pop_front());
    drive(edge_n + 1);
    edge_n++;
  endtask

  task automatic hold_reset();
    @(negedge clock);
    reset  = 1'b0;
    wr_req = 1'b0;
    #1;
    check("reset_values", outv(), 16'h0FFF);
    repeat (2) @(negedge clock);
    model_reset();
  endtask

  task automatic release_reset();
    drive(0);
    reset = 1'b1;
  endtask

  task automatic run_to(input int e);
    while (edge_n <= e) cycle();
  endtask

  vec_t tbl[$];

  initial begin
    int a1, a2, a3, ce, ae, cnt, t;

    // Reset release with no requests: first trigger and read window.
    hold_reset();
    release_reset();
    run_to(129);
    check("first_chs_edge", first_set(13, 0, 129), 100);
    cnt = 0;
    for (int i = 0; i < 130; i++) cnt += int'(log_v[i][14]);
    check("rdwin_busy_cycles", cnt, W);
    cnt = 0;
    for (int i = 0; i < 130; i++) cnt += int'(log_v[i][12]) + int'(log_v[i][3:0] != 4'hF);
    check("idle_bus_levels", cnt, 0);

    // Single write 0x23 <= 0x12, phase-by-phase table.
    tbl = '{
      '{0,  mk(1, 1, 1, 8'hFF, 1, 1, 1)}, '{1,  mk(0, 1, 1, 8'hFF, 0, 1, 1)},
      '{2,  mk(0, 1, 1, 8'hFF, 0, 1, 0)}, '{3,  mk(0, 1, 1, 8'hFF, 0, 0, 0)},
      '{4,  mk(0, 1, 1, 8'h23, 0, 0, 0)}, '{8,  mk(0, 1, 1, 8'h23, 0, 0, 0)},
      '{9,  mk(0, 1, 1, 8'h23, 0, 1, 0)}, '{10, mk(0, 1, 1, 8'h23, 0, 1, 1)},
      '{11, mk(0, 1, 1, 8'h23, 1, 1, 1)}, '{12, mk(0, 1, 1, 8'h23, 1, 1, 1)},
      '{13, mk(0, 1, 1, 8'hFF, 1, 1, 1)}, '{21, mk(0, 1, 1, 8'hFF, 1, 1, 0)},
      '{22, mk(0, 1, 1, 8'hFF, 1, 0, 0)}, '{23, mk(0, 1, 1, 8'h12, 1, 0, 0)},
      '{27, mk(0, 1, 1, 8'h12, 1, 0, 0)}, '{28, mk(0, 1, 1, 8'h12, 1, 1, 0)},
      '{29, mk(0, 1, 1, 8'h12, 1, 1, 1)}, '{30, mk(0, 1, 1, 8'h12, 1, 1, 1)},
      '{31, mk(0, 1, 1, 8'hFF, 1, 1, 1)}, '{40, mk(0, 1, 1, 8'hFF, 1, 1, 1)},
      '{41, mk(0, 0, 0, 8'hFF, 1, 1, 1)}
    };
    hold_reset();
    rq.push_back('{8'h23, 8'h12, 0});
    release_reset();
    foreach (tbl[i]) begin
      run_to(tbl[i].phase);
      check($sformatf("write_phase_%0d", tbl[i].phase), log_v[tbl[i].phase], tbl[i].exp);
    end

    // Request and pending trigger in the same cycle: trigger first.
    hold_reset();
    rq.push_back('{8'h40, 8'h5A, 100});
    release_reset();
    run_to(180);
    ce = first_set(13, 0, 180);
    ae = first_set(15, 0, 180);
    check("collide_chs_edge", ce, 100);
    check("collide_ack_delay", ae - ce, W + 1);

    // Period wrap at phase 10 of a write: trigger deferred to first IDLE cycle.
    hold_reset();
    rq.push_back('{8'h31, 8'h07, 89});
    release_reset();
    run_to(180);
    ce = first_set(13, 0, 180);
    check("defer_ack_edge", first_set(15, 0, 180), 89);
    check("defer_chs_after_write", ce > 89 + 40, 1);
    check("defer_latency_bound", (ce - 99) <= 42 && ce >= 0, 1);
    check("defer_chs_edge", ce, 131);

    // Reset in the data phase of a write.
    hold_reset();
    rq.push_back('{8'h52, 8'h34, 0});
    release_reset();
    run_to(24);
    check("abort_data_phase", log_v[24][11:4], 8'h34);
    #2;
    reset = 1'b0;
    #1;
    check("abort_idle_levels", outv(), 16'h0FFF);
    repeat (2) @(negedge clock);
    model_reset();
    release_reset();
    run_to(59);
    check("abort_no_ack", first_set(15, 0, 59), -1);

    // Three queued writes with wr_req held.
    hold_reset();
    rq.push_back('{8'h26, 8'h16, 0});
    rq.push_back('{8'h25, 8'h03, 0});
    rq.push_back('{8'h24, 8'h22, 0});
    release_reset();
    run_to(200);
    a1 = first_set(15, 0, 200);
    a2 = first_set(15, a1 + 1, 200);
    a3 = first_set(15, a2 + 1, 200);
    check("queue_ack1", a1, 0);
    check("queue_ack2", a2, 42);
    check("queue_ack3", a3, 84);
    check("queue_addr1", log_v[0 + 6][11:4], 8'h26);
    check("queue_data1", log_v[0 + 25][11:4], 8'h16);
    check("queue_addr2", log_v[42 + 6][11:4], 8'h25);
    check("queue_data2", log_v[42 + 25][11:4], 8'h03);
    check("queue_addr3", log_v[84 + 6][11:4], 8'h24);
    check("queue_data3", log_v[84 + 25][11:4], 8'h22);

    // Randomized request stream against the model.
    hold_reset();
    t = 0;
    for (int i = 0; i < 40; i++) begin
      t += $urandom_range(0, 70);
      rq.push_back('{8'($urandom), 8'($urandom), t});
    end
    release_reset();
    while (rq.size() > 0 && edge_n < 7000) cycle();
    repeat (50) cycle();
    check("random_drain", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rtc_write_seq.md
Name: rtc_write_seq

Overview:
- Upstream bus master and scheduler for the RTC multiplexed address/data bus.
- Drives write transactions (address phase, then data phase) to program time, date and timer registers.
- Periodically pulses `chs` to start the downstream RTC read sequencer, and holds off its own writes while that read burst owns the bus.
- Outputs `bus_sel` to steer the top-level bus mux between this block and the read sequencer.

Parameters:
- RD_PERIOD, 1000000, clock cycles between successive read triggers.
- RD_WINDOW, 450, cycles reserved for the read burst after a `chs` pulse (10 registers x 41 cycles + margin).
- CNT_W, 20, width of the period counter; must satisfy 2^CNT_W > RD_PERIOD.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_req  in  1  write request, level; requester holds it until `wr_ack`.
- wr_addr  in  8  RTC register address.
- wr_data  in  8  BCD/control data to write.
- wr_ack  out  1  one-cycle pulse: request accepted, `wr_addr`/`wr_data` latched.
- busy  out  1  high while in WRITE or RDWIN.
- chs  out  1  one-cycle read-start pulse to the read sequencer.
- bus_sel  out  1  1 = this block drives the RTC bus; 0 = the read sequencer does.
- ADout  out  8  bus data/address out.
- ad  out  1  address strobe, active-low.
- wr  out  1  write strobe, active-low.
- rd  out  1  read strobe, active-low; held 1 by this block at all times.
- cs  out  1  chip select, active-low.

Behaviour:
- Reset (`reset`=0, async):
  - ad=wr=rd=cs=1, ADout=8'hFF.
  - chs=0, wr_ack=0, busy=0, bus_sel=0.
  - State IDLE; phase counter=0, period counter=0, trig_pend=0.
- Period counter: free-runs in every state.
  - At RD_PERIOD-1 it wraps to 0 and sets trig_pend.
  - trig_pend clears only when `chs` is issued.
- FSM states: IDLE, WRITE, RDWIN.
- IDLE:
  - If trig_pend: chs=1 for one cycle, clear trig_pend, go to RDWIN, load window counter with RD_WINDOW-1.
  - Else if wr_req: wr_ack=1 for one cycle, latch addr/data, bus_sel=1, phase=0, go to WRITE.
  - Read trigger wins when both occur in the same cycle; wr_req stays pending and is served after RDWIN.
- RDWIN:
  - bus_sel=0, busy=1; wr_req is ignored.
  - Window counter decrements; at 0, go to IDLE.
  - A trig_pend raised during RDWIN is served in the next IDLE cycle.
- WRITE: a 6-bit phase counter runs 0..40. Bus actions at each phase:
  - 0: ad=wr=cs=1, ADout=FF.
  - 1: ad=0.
  - 2: cs=0.
  - 3: wr=0.
  - 4: ADout=addr.
  - 9: wr=1.
  - 10: cs=1.
  - 11: ad=1.
  - 13: ADout=FF.
  - 21: cs=0.
  - 22: wr=0.
  - 23: ADout=data.
  - 28: wr=1.
  - 29: cs=1.
  - 31: ADout=FF.
  - 40: go to IDLE; bus_sel=0 on the following cycle.
  - All other phases: outputs hold.
  - Total: 41 cycles from entry to IDLE.
- A write in progress is never aborted by trig_pend; the trigger waits for IDLE, so maximum trigger latency is 42 cycles.
- `busy` = (state != IDLE), registered.
- Back-to-back writes: wr_req held high after wr_ack starts the next write at the first IDLE cycle if no trigger is pending. Minimum spacing between wr_ack pulses is 42 cycles.
- Reset asserted mid-WRITE: bus returns to idle levels immediately (ad/wr/cs=1, ADout=FF) and the latched request is discarded; the requester must re-request.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release, no requests, RD_PERIOD=100, RD_WINDOW=20 → first chs pulse at cycle 100 after release; busy high for 20 cycles; bus_sel=0 throughout; ad/wr/rd/cs stay 1.
- wr_req with addr=8'h23, data=8'h12 while idle → wr_ack next cycle, then:
  - ADout=23 with ad=0, cs=0, wr=0 over phases 4..8.
  - ADout=12 with wr=0, cs=0 over phases 23..27.
  - rd=1 throughout; busy falls 41 cycles after entry.
- wr_req and trig_pend asserted in the same cycle → chs pulses first; wr_ack arrives exactly RD_WINDOW+1 cycles later.
- Period wrap during a WRITE at phase 10 → no chs until the WRITE completes; chs fires on the first IDLE cycle, at most 42 cycles after the wrap.
- reset pulled low at phase 24 of a write (ADout=data) → same cycle: ADout=FF, ad=wr=cs=1, busy=0; no wr_ack for the aborted request after release.
- Three queued writes (0x26=16, 0x25=03, 0x24=22), wr_req held → three wr_ack pulses 42 cycles apart; correct addr/data on each data phase.
